// File: rtl/cmd_link_pkg.sv
// Shared definitions for the FE command link blocks: FSM state encodings,
// bus register map, configuration/status bit positions and memory sizing.
package cmd_link_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [15:0] ADDR_SOFT_RST   = 16'd0;
    localparam logic [15:0] ADDR_ARM_STATUS = 16'd1;
    localparam logic [15:0] ADDR_CONF       = 16'd2;
    localparam logic [15:0] ADDR_SIZE_LO    = 16'd3;
    localparam logic [15:0] ADDR_SIZE_HI    = 16'd4;
    localparam logic [15:0] ADDR_CNT_LO     = 16'd5;
    localparam logic [15:0] ADDR_CNT_HI     = 16'd6;
    localparam logic [15:0] ADDR_SCRATCH    = 16'd7;
    localparam logic [15:0] ADDR_MEM_BASE   = 16'd8;

    localparam int CONF_NEGEDGE_BIT  = 0;
    localparam int CONF_TRIG_ONE_BIT = 1;
    localparam logic [7:0] CONF_RESET = 8'h02;

    // Memory address width: MEM_ADDR_W = $clog2(MEM_BYTES)
    function automatic int mem_addr_w(input int mem_bytes);
        return $clog2(mem_bytes);
    endfunction

endpackage

// File: rtl/cmd_rx_edge_sync.sv
// Brings the asynchronous command clock/data into BUS_CLK with 2-FF
// synchronizers; a third clock stage gives edge detection. The strobe and
// sampled bit are registered, so a link edge shows up three cycles later.
module cmd_rx_edge_sync
    import cmd_link_pkg::*;
(
    input  logic BUS_CLK,
    input  logic rst_i,
    input  logic cmd_clk_i,
    input  logic cmd_data_i,
    input  logic negedge_i,
    output logic sample_vld_o,
    output logic sample_bit_o
);

    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic data_s1_q, data_s2_q;
    logic vld_q, bit_q;
    logic edge_d;

    // Selected link edge, seen on the synchronized clock
    always_comb begin
        edge_d = negedge_i ? (!clk_s2_q && clk_s3_q) : (clk_s2_q && !clk_s3_q);
    end

    // Synchronizer chains and registered sample strobe
    always_ff @(posedge BUS_CLK) begin
        if (rst_i) begin
            clk_s1_q  <= 1'b0;
            clk_s2_q  <= 1'b0;
            clk_s3_q  <= 1'b0;
            data_s1_q <= 1'b0;
            data_s2_q <= 1'b0;
            vld_q     <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            clk_s1_q  <= cmd_clk_i;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= cmd_data_i;
            data_s2_q <= data_s1_q;
            vld_q     <= edge_d;
            bit_q     <= data_s2_q;
        end
    end

    assign sample_vld_o = vld_q;
    assign sample_bit_o = bit_q;

endmodule

// File: rtl/cmd_rx_capture.sv
// Command link receiver: deserializes MSB-first link bits into a bus-readable
// byte memory and reports the captured bit count.
// Optional build macro CMD_RX_IDLE_TIMEOUT_EN: TIMEOUT_BITS consecutive zero
// bits end a capture early and set status bit 3.
//
//  state   | meaning
//  IDLE    | after reset, nothing armed
//  ARMED   | waiting for the first (trigger) bit
//  CAPTURE | shifting bits into memory until size (or idle timeout)
//  DONE    | capture complete, count and memory valid
module cmd_rx_capture
    import cmd_link_pkg::*;
#(
    parameter int MEM_BYTES    = 2048,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic [15:0] BUS_ADD,
    input  logic [7:0]  BUS_DATA_IN,
    input  logic        BUS_RD,
    input  logic        BUS_WR,
    output logic [7:0]  BUS_DATA_OUT,
    input  logic        CMD_CLK_IN,
    input  logic        CMD_DATA_IN,
    output logic        RX_READY,
    output logic        RX_DONE_FLAG
);

    localparam int AW = mem_addr_w(MEM_BYTES);
    localparam logic [15:0] MAX_BITS = 16'(MEM_BYTES * 8);
`ifdef CMD_RX_IDLE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic        rst_int, arm;
    logic [7:0]  conf_q, size_lo_q, size_hi_q, scratch_q;
    logic [15:0] size_raw, size_lim;
    logic        size_ovf;
    logic        smp_vld, smp_bit;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc, zrun_q, zrun_d, zrun_inc;
    logic [7:0]  shift_q, shift_d, shifted;
    logic        ovf_q, ovf_d, tmo_q, tmo_d, done_flag_q;
    logic        take, size_hit, tmo_hit;
    logic        cap_we;
    logic [7:0]  cap_data;
    logic [AW-1:0] cap_idx, bus_mem_idx, mem_widx;
    logic        bus_mem_we, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_q [MEM_BYTES];
    logic [7:0]  mem_rd_q, reg_rd_q, reg_rd_d, status;
    logic        sel_mem_q;

    assign rst_int  = RST | (BUS_WR && BUS_ADD == ADDR_SOFT_RST);
    assign arm      = BUS_WR && BUS_ADD == ADDR_ARM_STATUS;
    assign size_raw = {size_hi_q, size_lo_q};
    assign size_ovf = size_raw > MAX_BITS;
    assign size_lim = size_ovf ? MAX_BITS : size_raw;

    cmd_rx_edge_sync u_sync (
        .BUS_CLK      (BUS_CLK),
        .rst_i        (rst_int),
        .cmd_clk_i    (CMD_CLK_IN),
        .cmd_data_i   (CMD_DATA_IN),
        .negedge_i    (conf_q[CONF_NEGEDGE_BIT]),
        .sample_vld_o (smp_vld),
        .sample_bit_o (smp_bit)
    );

    // Configuration register file
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            conf_q    <= CONF_RESET;
            size_lo_q <= 8'h00;
            size_hi_q <= 8'h00;
            scratch_q <= 8'h00;
        end else if (BUS_WR) begin
            case (BUS_ADD)
                ADDR_CONF:    conf_q    <= BUS_DATA_IN;
                ADDR_SIZE_LO: size_lo_q <= BUS_DATA_IN;
                ADDR_SIZE_HI: size_hi_q <= BUS_DATA_IN;
                ADDR_SCRATCH: scratch_q <= BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    // Capture FSM next state; the last bit and the DONE transition share a
    // cycle so a trailing partial byte is written together with the state change
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        zrun_d   = zrun_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        take     = 1'b0;
        cap_we   = 1'b0;
        cap_data = 8'h00;
        cap_idx  = cnt_q[AW+2:3];
        shifted  = {shift_q[6:0], smp_bit};
        cnt_inc  = cnt_q + 16'd1;
        zrun_inc = smp_bit ? 16'd0 : zrun_q + 16'd1;
        size_hit = (cnt_inc == size_lim);
        tmo_hit  = TIMEOUT_EN && (zrun_inc == 16'(TIMEOUT_BITS));
        if (arm) begin
            state_d = ST_ARMED;
            cnt_d   = 16'd0;
            shift_d = 8'h00;
            zrun_d  = 16'd0;
            ovf_d   = 1'b0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (size_lim == 16'd0)
                        state_d = ST_DONE;
                    else if (smp_vld && (smp_bit || !conf_q[CONF_TRIG_ONE_BIT]))
                        take = 1'b1;
                end
                ST_CAPTURE: take = smp_vld;
                default: ;
            endcase
        end
        if (take) begin
            state_d = ST_CAPTURE;
            cnt_d   = cnt_inc;
            shift_d = shifted;
            zrun_d  = zrun_inc;
            if (cnt_inc[2:0] == 3'd0) begin
                cap_we   = 1'b1;
                cap_data = shifted;
            end
            if (size_hit || tmo_hit) begin
                state_d = ST_DONE;
                ovf_d   = size_hit && size_ovf;
                tmo_d   = tmo_hit;
                if (cnt_inc[2:0] != 3'd0) begin
                    cap_we   = 1'b1;
                    cap_data = shifted << (4'd8 - {1'b0, cnt_inc[2:0]});
                end
            end
        end
    end

    // Capture FSM state and datapath registers
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            shift_q     <= 8'h00;
            zrun_q      <= 16'd0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            done_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            zrun_q      <= zrun_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            done_flag_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign RX_READY     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign RX_DONE_FLAG = done_flag_q;

    // Single write port: capture wins, bus writes are dropped during CAPTURE
    assign bus_mem_idx = AW'(BUS_ADD - ADDR_MEM_BASE);
    assign bus_mem_we  = BUS_WR && (BUS_ADD >= ADDR_MEM_BASE) && (state_q != ST_CAPTURE);
    assign mem_we      = !rst_int && (cap_we || bus_mem_we);
    assign mem_widx    = cap_we ? cap_idx : bus_mem_idx;
    assign mem_wdata   = cap_we ? cap_data : BUS_DATA_IN;

    // Capture memory write port (contents survive reset)
    always_ff @(posedge BUS_CLK) begin
        if (mem_we)
            mem_q[mem_widx] <= mem_wdata;
    end

    // Capture memory synchronous read port
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RD)
            mem_rd_q <= mem_q[bus_mem_idx];
    end

    assign status = {4'b0000, tmo_q, ovf_q,
                     (state_q == ST_ARMED) || (state_q == ST_CAPTURE),
                     state_q == ST_DONE};

    // Register read mux
    always_comb begin
        reg_rd_d = 8'h00;
        case (BUS_ADD)
            ADDR_ARM_STATUS: reg_rd_d = status;
            ADDR_CONF:       reg_rd_d = conf_q;
            ADDR_SIZE_LO:    reg_rd_d = size_lo_q;
            ADDR_SIZE_HI:    reg_rd_d = size_hi_q;
            ADDR_CNT_LO:     reg_rd_d = cnt_q[7:0];
            ADDR_CNT_HI:     reg_rd_d = cnt_q[15:8];
            ADDR_SCRATCH:    reg_rd_d = scratch_q;
            default: ;
        endcase
    end

    // Registered read data; memory vs register select follows the address
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            reg_rd_q  <= 8'h00;
            sel_mem_q <= 1'b0;
        end else if (BUS_RD) begin
            reg_rd_q  <= reg_rd_d;
            sel_mem_q <= BUS_ADD >= ADDR_MEM_BASE;
        end
    end

    assign BUS_DATA_OUT = sel_mem_q ? mem_rd_q : reg_rd_q;

endmodule

// File: tb/tb_cmd_rx_capture.sv
// Self-checking bench for cmd_rx_capture (MEM_BYTES=16 to reach the clamp).
module tb_cmd_rx_capture;

    logic        BUS_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] BUS_ADD = 16'd0;
    logic [7:0]  BUS_DATA_IN = 8'd0;
    logic        BUS_RD = 1'b0;
    logic        BUS_WR = 1'b0;
    logic [7:0]  BUS_DATA_OUT;
    logic        CMD_CLK_IN = 1'b0;
    logic        CMD_DATA_IN = 1'b0;
    logic        RX_READY;
    logic        RX_DONE_FLAG;

    typedef struct {
        string       tag;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_pulses = 0;
    logic [7:0] rd;
    logic [7:0] ovf_bytes [16];

    cmd_rx_capture #(.MEM_BYTES(16), .TIMEOUT_BITS(16)) dut (
        .BUS_CLK      (BUS_CLK),
        .RST          (RST),
        .BUS_ADD      (BUS_ADD),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_RD       (BUS_RD),
        .BUS_WR       (BUS_WR),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .CMD_CLK_IN   (CMD_CLK_IN),
        .CMD_DATA_IN  (CMD_DATA_IN),
        .RX_READY     (RX_READY),
        .RX_DONE_FLAG (RX_DONE_FLAG)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    always @(negedge BUS_CLK) if (RX_DONE_FLAG === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge BUS_CLK);
        BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
        @(negedge BUS_CLK);
        BUS_WR = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge BUS_CLK);
        BUS_ADD = a; BUS_RD = 1'b1;
        @(negedge BUS_CLK);
        BUS_RD = 1'b0;
        d = BUS_DATA_OUT;
    endtask

    task automatic push_exp(input string tag, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.tag = tag; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [7:0] d;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus_read(e.addr, d);
            check(e.tag, {24'd0, d}, {24'd0, e.data});
        end
    endtask

    // One link bit at BUS_CLK/8; data changes mid-low so both edges see it stable
    task automatic send_bit(input logic b);
        CMD_CLK_IN = 1'b0;
        repeat (2) @(negedge BUS_CLK);
        CMD_DATA_IN = b;
        repeat (2) @(negedge BUS_CLK);
        CMD_CLK_IN = 1'b1;
        repeat (4) @(negedge BUS_CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic flush();
        CMD_CLK_IN = 1'b0;
        repeat (8) @(negedge BUS_CLK);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (RX_READY !== 1'b1 && n < budget) begin
            @(negedge BUS_CLK);
            n++;
        end
        check(tag, {31'd0, RX_READY}, 32'd1);
    endtask

    task automatic setup(input logic [7:0] conf, input logic [15:0] size);
        bus_write(16'd2, conf);
        bus_write(16'd3, size[7:0]);
        bus_write(16'd4, size[15:8]);
        bus_write(16'd1, 8'h00);
    endtask

    initial begin
        int p0;
        repeat (4) @(negedge BUS_CLK);
        RST = 1'b0;
        @(negedge BUS_CLK);

        // reset state
        check("rst_ready", {31'd0, RX_READY}, 32'd1);
        check("rst_doneflag", {31'd0, RX_DONE_FLAG}, 32'd0);
        check("rst_dout", {24'd0, BUS_DATA_OUT}, 32'd0);
        push_exp("rst_status", 16'd1, 8'h00);
        push_exp("rst_conf", 16'd2, 8'h02);
        push_exp("rst_size_lo", 16'd3, 8'h00);
        push_exp("rst_cnt_lo", 16'd5, 8'h00);
        push_exp("rst_cnt_hi", 16'd6, 8'h00);
        push_exp("rst_scratch", 16'd7, 8'h00);
        drain();
        bus_write(16'd7, 8'h9C);
        push_exp("scratch_rw", 16'd7, 8'h9C);
        drain();

        // size 16, trigger off
        setup(8'h00, 16'd16);
        p0 = done_pulses;
        send_byte(8'hA5); send_byte(8'h3C); flush();
        wait_ready("t1_wait", 200);
        check("t1_done_pulses", done_pulses - p0, 32'd1);
        push_exp("t1_mem0", 16'd8, 8'hA5);
        push_exp("t1_mem1", 16'd9, 8'h3C);
        push_exp("t1_cnt_lo", 16'd5, 8'd16);
        push_exp("t1_cnt_hi", 16'd6, 8'd0);
        push_exp("t1_status", 16'd1, 8'h01);
        drain();

        // size 12, trigger on one; leading zeros ignored, tail left-aligned
        setup(8'h02, 16'd12);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_byte(8'hB7); send_byte(8'h90); flush();
        wait_ready("t2_wait", 200);
        push_exp("t2_mem0", 16'd8, 8'hB7);
        push_exp("t2_mem1", 16'd9, 8'h90);
        push_exp("t2_cnt_lo", 16'd5, 8'd12);
        drain();

        // falling-edge sampling, size 8
        setup(8'h01, 16'd8);
        send_byte(8'h6D); flush();
        wait_ready("t3_wait", 200);
        push_exp("t3_mem0", 16'd8, 8'h6D);
        push_exp("t3_cnt_lo", 16'd5, 8'd8);
        drain();

        // size beyond memory: clamp to 128 bits, overflow; 17th byte dropped
        setup(8'h00, 16'h7FFF);
        for (int k = 0; k < 16; k++) begin
            ovf_bytes[k] = 8'(k * 8'h13 + 8'h21);
            send_byte(ovf_bytes[k]);
        end
        send_byte(8'hFF); flush();
        wait_ready("t4_wait", 200);
        push_exp("t4_status", 16'd1, 8'h05);
        push_exp("t4_cnt_lo", 16'd5, 8'h80);
        push_exp("t4_cnt_hi", 16'd6, 8'h00);
        for (int k = 0; k < 16; k++) push_exp($sformatf("t4_mem%0d", k), 16'(8 + k), ovf_bytes[k]);
        drain();

        // bus memory write in DONE, with address wrap
        bus_write(16'd28, 8'h5A);
        push_exp("wrap_mem4", 16'd12, 8'h5A);
        drain();

        // re-arm mid-capture
        setup(8'h00, 16'd8);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        flush();
        push_exp("t5_mid_cnt", 16'd5, 8'd5);
        push_exp("t5_mid_status", 16'd1, 8'h02);
        drain();
        bus_write(16'd1, 8'h00);
        push_exp("t5_rearm_cnt", 16'd5, 8'd0);
        drain();
        send_byte(8'h4E); flush();
        wait_ready("t5_wait", 200);
        push_exp("t5_mem0", 16'd8, 8'h4E);
        push_exp("t5_cnt_lo", 16'd5, 8'd8);
        drain();

        // soft reset during capture; bus write during capture dropped
        setup(8'h00, 16'd16);
        send_byte(8'hC3); send_bit(1'b1); send_bit(1'b0);
        bus_write(16'd9, 8'hEE);
        check("t6_busy", {31'd0, RX_READY}, 32'd0);
        bus_write(16'd0, 8'h00);
        @(negedge BUS_CLK);
        check("t6_ready", {31'd0, RX_READY}, 32'd1);
        flush();
        push_exp("t6_conf", 16'd2, 8'h02);
        push_exp("t6_cnt_lo", 16'd5, 8'd0);
        push_exp("t6_status", 16'd1, 8'h00);
        push_exp("t6_mem0", 16'd8, 8'hC3);
        push_exp("t6_mem1", 16'd9, ovf_bytes[1]);
        drain();

        // size 0: straight to DONE, nothing written
        bus_write(16'd1, 8'h00);
        repeat (3) @(negedge BUS_CLK);
        push_exp("t7_status", 16'd1, 8'h01);
        push_exp("t7_cnt_lo", 16'd5, 8'd0);
        push_exp("t7_mem0", 16'd8, 8'hC3);
        drain();

        // idle-zero run after 0xFF
        setup(8'h00, 16'd64);
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); flush();
`ifdef CMD_RX_IDLE_TIMEOUT_EN
        wait_ready("t8_wait", 200);
        push_exp("t8_status", 16'd1, 8'h09);
`else
        push_exp("t8_status", 16'd1, 8'h02);
`endif
        push_exp("t8_cnt_lo", 16'd5, 8'd24);
        push_exp("t8_mem0", 16'd8, 8'hFF);
        push_exp("t8_mem1", 16'd9, 8'h00);
        drain();

        bus_read(16'd7, rd);
        check("final_scratch_kept", {24'd0, rd}, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
